// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states,
// instruction opcode/funct fields and ALU operation codes.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC     = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_decoder.sv
// Combinational R-type funct to ALU operation mapping; unknown funct
// codes fall back to add.
module alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath with memory wait states.
// state      | meaning
// FETCH      | read instruction at PC, PC += 4 when memory completes
// DECODE     | branch target computed speculatively, dispatch on opcode
// MEMADR     | effective address = A + sign-extended immediate
// MEMREAD    | load access, held until mem_ready
// MEMWB      | load data written to rt
// MEMWRITE   | store access, held until mem_ready
// EXEC       | R-type ALU operation
// ALUWB      | R-type result written to rd
// BRANCH     | beq compare, PC loads target on zero
// ADDIEX     | A + sign-extended immediate
// ADDIWB     | addi result written to rt
// JUMP       | PC loads jump target
module multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_op,
    output logic       retire,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [2:0] funct_alu_op;
    logic       pc_write, branch;
    logic       mem_write_c, ir_write_c, reg_write_c, retire_c;

    alu_decoder u_alu_decoder (
        .funct  (funct),
        .alu_op (funct_alu_op)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        branch      = 1'b0;
        iord        = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        pc_src      = 2'b00;
        alu_op      = ALU_ADD;
        retire_c    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b  = 2'b01;
                ir_write_c = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        // unknown opcodes retire here as a nop
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_c = 1'b1;
                mem_to_reg  = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                // write strobe held for the whole access, including completion
                iord        = 1'b1;
                mem_write_c = 1'b1;
                retire_c    = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                reg_dst     = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_src    = 2'b01;
                branch    = 1'b1;
                retire_c  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // strobes are forced low while reset is held, whatever the state
    assign pc_en     = (pc_write | (branch & zero)) & ~rst;
    assign mem_write = mem_write_c & ~rst;
    assign ir_write  = ir_write_c & ~rst;
    assign reg_write = reg_write_c & ~rst;
    assign retire    = retire_c & ~rst;
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: every cycle's expected outputs
// are queued as stimulus is applied and compared against the DUT at negedge.
module tb_multicycle_control;

    typedef logic [19:0] vec_t;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXEC     = 4'd6;
    localparam logic [3:0] ST_ALUWB    = 4'd7;
    localparam logic [3:0] ST_BRANCH   = 4'd8;
    localparam logic [3:0] ST_ADDIEX   = 4'd9;
    localparam logic [3:0] ST_ADDIWB   = 4'd10;
    localparam logic [3:0] ST_JUMP     = 4'd11;

    logic       clk, rst, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, retire;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    string cur_test = "";
    vec_t  exp_q[$];

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .retire     (retire),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t row(logic [3:0] st, logic pe, logic io, logic mw, logic irw,
                                 logic rw, logic rd, logic m2r, logic asa, logic [1:0] asb,
                                 logic [1:0] pcs, logic [2:0] aop, logic ret);
        return {st, pe, io, mw, irw, rw, rd, m2r, asa, asb, pcs, aop, ret};
    endfunction

    function automatic vec_t e_fetch(logic mr, logic r);
        return row(ST_FETCH, mr & ~r, 0, 0, mr & ~r, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    endfunction
    function automatic vec_t e_decode(logic ret);
        return row(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, ret);
    endfunction
    function automatic vec_t e_memadr();
        return row(ST_MEMADR, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    endfunction
    function automatic vec_t e_memread();
        return row(ST_MEMREAD, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, 0);
    endfunction
    function automatic vec_t e_memwb();
        return row(ST_MEMWB, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b010, 1);
    endfunction
    function automatic vec_t e_memwrite(logic mr);
        return row(ST_MEMWRITE, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b010, mr);
    endfunction
    function automatic vec_t e_exec(logic [2:0] aop);
        return row(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, aop, 0);
    endfunction
    function automatic vec_t e_aluwb();
        return row(ST_ALUWB, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b010, 1);
    endfunction
    function automatic vec_t e_branch(logic z);
        return row(ST_BRANCH, z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 1);
    endfunction
    function automatic vec_t e_addiex();
        return row(ST_ADDIEX, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0);
    endfunction
    function automatic vec_t e_addiwb();
        return row(ST_ADDIWB, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b010, 1);
    endfunction
    function automatic vec_t e_jump();
        return row(ST_JUMP, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b010, 1);
    endfunction

    function automatic vec_t dut_vec();
        return {state, pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, pc_src, alu_op, retire};
    endfunction

    // One clock cycle: apply inputs, queue the expectation, compare at negedge.
    task automatic step(input logic mr, input logic z, input vec_t e);
        vec_t got, want;
        mem_ready = mr;
        zero      = z;
        exp_q.push_back(e);
        @(negedge clk);
        got  = dut_vec();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h (state %0d) expected %h (state %0d)",
                     cur_test, cyc, got, got[19:16], want, want[19:16]);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cur_test = "reset";
        opcode = 6'b100011;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b1));
        step(1'b1, 1'b1, e_fetch(1'b1, 1'b1));
        rst = 1'b0;
    endtask

    task automatic test_lw();
        int start;
        cur_test = "lw";
        opcode = 6'b100011;
        funct  = 6'b000000;
        start  = cyc;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b0));
        step(1'b1, 1'b0, e_memadr());
        step(1'b1, 1'b0, e_memread());
        step(1'b1, 1'b0, e_memwb());
        checks++;
        if (cyc - start !== 5) begin
            errors++;
            $display("FAIL lw_latency: got %0d expected 5", cyc - start);
        end
    endtask

    task automatic test_sw();
        cur_test = "sw";
        opcode = 6'b101011;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b0));
        step(1'b1, 1'b0, e_memadr());
        step(1'b1, 1'b0, e_memwrite(1'b1));
    endtask

    task automatic test_rtype();
        logic [5:0] fn_tab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111000};
        logic [2:0] op_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
        cur_test = "rtype";
        opcode = 6'b000000;
        for (int i = 0; i < 6; i++) begin
            funct = fn_tab[i];
            step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
            step(1'b1, 1'b0, e_decode(1'b0));
            step(1'b1, 1'b0, e_exec(op_tab[i]));
            step(1'b1, 1'b0, e_aluwb());
        end
    endtask

    task automatic test_beq();
        cur_test = "beq";
        opcode = 6'b000100;
        for (int z = 1; z >= 0; z--) begin
            step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
            step(1'b1, 1'b0, e_decode(1'b0));
            step(1'b1, z[0], e_branch(z[0]));
        end
    endtask

    task automatic test_addi_jump();
        cur_test = "addi";
        opcode = 6'b001000;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b0));
        step(1'b1, 1'b0, e_addiex());
        step(1'b1, 1'b0, e_addiwb());
        cur_test = "jump";
        opcode = 6'b000010;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b0));
        step(1'b1, 1'b0, e_jump());
    endtask

    task automatic test_undefined();
        cur_test = "undefined";
        opcode = 6'b111111;
        step(1'b1, 1'b1, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b1, e_decode(1'b1));
        opcode = 6'b000011;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b1));
    endtask

    task automatic test_wait_states();
        int start;
        cur_test = "wait_states";
        opcode = 6'b100011;
        start  = cyc;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_fetch(1'b0, 1'b0));
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b0, 1'b0, e_decode(1'b0));
        step(1'b0, 1'b0, e_memadr());
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, e_memread());
        step(1'b1, 1'b0, e_memread());
        step(1'b0, 1'b0, e_memwb());
        checks++;
        if (cyc - start !== 11) begin
            errors++;
            $display("FAIL lw_wait_latency: got %0d expected 11", cyc - start);
        end
    endtask

    task automatic test_reset_in_memwrite();
        vec_t got, want;
        cur_test = "reset_memwrite";
        opcode = 6'b101011;
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b0));
        step(1'b1, 1'b0, e_memadr());
        step(1'b0, 1'b0, e_memwrite(1'b0));
        // still in MEMWRITE with the store pending; hit reset between edges
        mem_ready = 1'b0;
        #2;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_mem_write: got %b expected 1", mem_write);
        end
        rst = 1'b1;
        #1;
        exp_q.push_back(e_fetch(1'b0, 1'b1));
        got  = dut_vec();
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL async_reset_memwrite: got %h expected %h", got, want);
        end
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b1));
        rst = 1'b0;
        opcode = 6'b001000;
        step(1'b0, 1'b0, e_fetch(1'b0, 1'b0));
        step(1'b1, 1'b0, e_fetch(1'b1, 1'b0));
        step(1'b1, 1'b0, e_decode(1'b0));
        step(1'b1, 1'b0, e_addiex());
        step(1'b1, 1'b0, e_addiwb());
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'b000000;
        funct     = 6'b000000;
        zero      = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_beq();
        test_addi_jump();
        test_undefined();
        test_wait_states();
        test_reset_in_memwrite();
        test_lw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 opcode  input  6  instruction register bits [31:26].
REQ-004 funct  input  6  instruction register bits [5:0].
REQ-005 zero  input  1  ALU result-equals-zero flag, combinational from datapath.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pc_en  output  1  PC load enable; equals pc_write OR (branch AND zero).
REQ-008 iord  output  1  memory address select: 0 = PC, 1 = ALU-out register.
REQ-009 mem_write, ir_write, reg_write  output  1 each  write strobes.
REQ-010 reg_dst  output  1  0 = rt, 1 = rd. mem_to_reg  output  1  0 = ALU-out, 1 = memory data.
REQ-011 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-012 alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-013 pc_src  output  2  00 = ALU result, 01 = ALU-out register, 10 = jump target.
REQ-014 alu_op  output  3  ALU encoding: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-015 retire  output  1  single-cycle pulse in the final state of each instruction.
REQ-016 state  output  4  current state, for debug.

Function
REQ-017 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-018 Default outputs in every state SHALL be: all strobes 0, selects 0, alu_op = 010.
REQ-019 FETCH SHALL drive alu_src_b=01 and alu_op=010. ir_write and pc_write SHALL assert only while mem_ready=1. FETCH SHALL be held while mem_ready=0.
REQ-020 FETCH SHALL advance to DECODE when mem_ready=1.
REQ-021 DECODE SHALL drive alu_src_b=11 and alu_op=010.
REQ-022 DECODE transitions: lw/sw (100011/101011) -> MEMADR; R-type (000000) -> EXEC; beq (000100) -> BRANCH; addi (001000) -> ADDIEX; j (000010) -> JUMP; any other opcode -> FETCH with retire=1 (executed as a nop).
REQ-023 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=010, then go to MEMREAD for lw or MEMWRITE for sw.
REQ-024 MEMREAD SHALL drive iord=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-025 MEMWB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0 and retire=1, then go to FETCH.
REQ-026 MEMWRITE SHALL drive iord=1. mem_write SHALL assert only while mem_ready=0 or on the completing cycle; the state SHALL hold until mem_ready=1, then emit retire=1 and go to FETCH.
REQ-027 EXEC SHALL drive alu_src_a=1, alu_src_b=00, with alu_op from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other -> 010. EXEC SHALL go to ALUWB.
REQ-028 ALUWB SHALL drive reg_write=1, reg_dst=1 and retire=1, then go to FETCH.
REQ-029 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, internal branch=1 and retire=1, then go to FETCH.
REQ-030 ADDIEX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=010, then go to ADDIWB. ADDIWB SHALL drive reg_write=1, reg_dst=0, mem_to_reg=0 and retire=1, then go to FETCH.
REQ-031 JUMP SHALL drive pc_src=10, pc_write=1 and retire=1, then go to FETCH.
REQ-032 With mem_ready held at 1, instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, undefined opcode 2.

Reset
REQ-033 rst SHALL force state to FETCH asynchronously.
REQ-034 While rst=1, all strobes (pc_en, mem_write, ir_write, reg_write, retire) SHALL be 0 regardless of state.
REQ-035 Assertion of rst mid-instruction SHALL abandon the instruction with no write strobe emitted.
REQ-036 After rst deasserts, the first fetch SHALL occur on the first edge where mem_ready=1.

Structure
REQ-037 A shared package mips_pkg SHALL hold the state enumeration, the opcode and funct constants, and the alu_op codes.
REQ-038 funct decoding SHALL live in the sub-module alu_decoder, which is purely combinational.
REQ-039 The FSM SHALL consist of one state register and combinational next-state/output logic.

Verification
REQ-040 Reset, then lw with mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB; retire on cycle 5; reg_write=1 with mem_to_reg=1.
REQ-041 R-type with funct=100010 -> alu_op=110 in EXEC; ALUWB asserts reg_write=1, reg_dst=1.
REQ-042 beq with zero=1 in BRANCH -> pc_en=1, pc_src=01. Same with zero=0 -> pc_en=0.
REQ-043 mem_ready=0 for 3 cycles in FETCH and in MEMREAD -> state holds; ir_write=0 and pc_en=0 while waiting; lw latency becomes 11.
REQ-044 opcode=111111 -> DECODE returns to FETCH with retire=1 and no write strobe.
REQ-045 rst asserted during MEMWRITE -> state immediately becomes FETCH with mem_write=0; normal fetch follows after release.
